// File: rtl/alu_pkg.sv
// Shared ALU definitions: the opcode map and the checker FSM states.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: (op, a, b) -> expected result.
// The reserved opcode yields 0 and raises o_rsvd so callers can treat it as an error.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_exp,
    output logic             o_rsvd
);

    logic w_lt;

    assign w_lt = $signed(i_a) < $signed(i_b);

    always_comb begin
        o_exp  = '0;
        o_rsvd = 1'b0;
        case (i_op)
            OP_AND:  o_exp = i_a & i_b;
            OP_OR:   o_exp = i_a | i_b;
            OP_XOR:  o_exp = i_a ^ i_b;
            OP_NOR:  o_exp = ~(i_a | i_b);
            OP_ADD:  o_exp = i_a + i_b;
            OP_SUB:  o_exp = i_a - i_b;
            OP_SLT:  o_exp = {{(WIDTH-1){1'b0}}, w_lt};
            default: o_rsvd = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_resp_checker.sv
// Response checker: accepts {op, A, B, R} vectors, compares R against the reference
// model one cycle after acceptance, and keeps pass/fail counts plus the first failure.
module alu_resp_checker
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_r,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_r,
    output logic [WIDTH-1:0] first_exp,
    output logic             done,
    output logic             pass
);

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_acc;

    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [WIDTH-1:0] r_s1_r;
    logic [CNT_W-1:0] r_s1_idx;

    logic             r_mismatch;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [CNT_W-1:0] r_first_idx;
    logic [WIDTH-1:0] r_first_r;
    logic [WIDTH-1:0] r_first_exp;

    logic             w_ready;
    logic             w_xfer;
    logic             w_last;
    logic             w_start;
    logic [WIDTH-1:0] w_exp;
    logic             w_rsvd;
    logic             w_fail;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .i_op   (r_s1_op),
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .o_exp  (w_exp),
        .o_rsvd (w_rsvd)
    );

    assign w_ready = (r_state == RUN) && (r_acc < r_num);
    assign w_xfer  = in_valid && w_ready;
    assign w_last  = w_xfer && (r_acc == r_num - 1'b1);
    assign w_start = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_fail  = w_rsvd || (r_s1_r != w_exp);

    // DRAIN waits for stage 2 to empty so done trails the final counter update by a cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = (num_vectors == '0) ? DONE : RUN;
            RUN:        if (w_last) w_next = DRAIN;
            DRAIN:      if (!r_s1_valid) w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num      <= '0;
            r_acc      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_r     <= '0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= w_xfer;
            if (w_start) begin
                r_num <= num_vectors;
                r_acc <= '0;
            end else if (w_xfer) begin
                r_acc <= r_acc + 1'b1;
            end
            if (w_xfer) begin
                r_s1_op  <= in_op;
                r_s1_a   <= in_a;
                r_s1_b   <= in_b;
                r_s1_r   <= in_r;
                r_s1_idx <= r_acc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mismatch  <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_first_idx <= '0;
            r_first_r   <= '0;
            r_first_exp <= '0;
        end else if (w_start) begin
            r_mismatch  <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_first_idx <= '0;
            r_first_r   <= '0;
            r_first_exp <= '0;
        end else begin
            r_mismatch <= r_s1_valid && w_fail;
            if (r_s1_valid) begin
                if (w_fail) begin
                    if (r_fail_cnt == '0) begin
                        r_first_idx <= r_s1_idx;
                        r_first_r   <= r_s1_r;
                        r_first_exp <= w_exp;
                    end
                    if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
                end else if (r_pass_cnt != '1) begin
                    r_pass_cnt <= r_pass_cnt + 1'b1;
                end
            end
        end
    end

    assign in_ready  = w_ready;
    assign mismatch  = r_mismatch;
    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign first_idx = r_first_idx;
    assign first_r   = r_first_r;
    assign first_exp = r_first_exp;
    assign done      = (r_state == DONE);
    assign pass      = (r_state == DONE) && (r_fail_cnt == '0);

endmodule

// File: tb/tb_alu_resp_checker.sv
// Randomized and directed bench for alu_resp_checker against an arithmetic reference
// model and a per-cycle scoreboard of expected mismatch pulses and counts.
module tb_alu_resp_checker;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_vectors;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [W-1:0]  in_r;
    logic          mismatch;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic [CW-1:0] first_idx;
    logic [W-1:0]  first_r;
    logic [W-1:0]  first_exp;
    logic          done;
    logic          pass;

    int checks = 0;
    int errors = 0;

    logic [2:0]   q_op[$];
    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];
    logic [W-1:0] q_r[$];

    alu_resp_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_vectors (num_vectors),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_r        (in_r),
        .mismatch    (mismatch),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt),
        .first_idx   (first_idx),
        .first_r     (first_r),
        .first_exp   (first_exp),
        .done        (done),
        .pass        (pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_exp(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint m  = 64'h1_0000_0000;
        int     sa = int'(a);
        int     sb = int'(b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a | b);
            3'd4:    return W'((ua + ub) % m);
            3'd5:    return W'((ua - ub + m) % m);
            3'd6:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    function automatic bit model_bad(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic [W-1:0] r);
        return (op == 3'd7) || (r != model_exp(op, a, b));
    endfunction

    task automatic add_vec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] r);
        q_op.push_back(op);
        q_a.push_back(a);
        q_b.push_back(b);
        q_r.push_back(r);
    endtask

    task automatic clear_vecs();
        q_op.delete();
        q_a.delete();
        q_b.delete();
        q_r.delete();
    endtask

    task automatic add_random(input int n);
        logic [2:0] op;
        logic [W-1:0] a, b, r;
        for (int i = 0; i < n; i++) begin
            op = 3'($urandom_range(7));
            a  = $urandom;
            b  = ($urandom_range(5) == 0) ? a : $urandom;
            r  = ($urandom_range(3) == 0) ? $urandom : model_exp(op, a, b);
            add_vec(op, a, b, r);
        end
    endtask

    // Runs one session over the queued vectors; abort_at >= 0 stops after that many transfers.
    task automatic run_session(input int gap, input int abort_at, input bit poke_start);
        int n;
        int acc = 0;
        int cycles = 0;
        bit pend = 0;
        bit pend_bad = 0;
        int pend_idx = 0;
        logic [W-1:0] pend_r = '0;
        logic [W-1:0] pend_exp = '0;
        int e_pass = 0;
        int e_fail = 0;
        int e_fidx = 0;
        logic [W-1:0] e_fr = '0;
        logic [W-1:0] e_fexp = '0;
        bit xfer;
        n = q_op.size();
        @(negedge clk);
        num_vectors = CW'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            in_valid = 1'b1;
            #1;
            check("zero_done", 64'(done), 64'd1);
            check("zero_pass", 64'(pass), 64'd1);
            check("zero_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
            check("zero_ready2", 64'(in_ready), 64'd0);
            check("zero_pcnt", 64'(pass_cnt), 64'd0);
            in_valid = 1'b0;
            return;
        end
        while (!(acc == n && !pend) && cycles < 2000) begin
            cycles++;
            in_valid = (acc < n) && ($urandom_range(99) >= gap);
            if (acc < n) begin
                in_op = q_op[acc];
                in_a  = q_a[acc];
                in_b  = q_b[acc];
                in_r  = q_r[acc];
            end else begin
                in_op = 3'($urandom_range(7));
                in_a  = $urandom;
            end
            if (poke_start) begin
                start = ($urandom_range(9) == 0);
                num_vectors = CW'($urandom_range(5));
            end
            #1;
            check("ready", 64'(in_ready), 64'(acc < n));
            @(posedge clk);
            xfer = in_valid && (acc < n);
            #1;
            check("mismatch", 64'(mismatch), 64'(pend && pend_bad));
            if (pend) begin
                if (pend_bad) begin
                    if (e_fail == 0) begin
                        e_fidx = pend_idx;
                        e_fr   = pend_r;
                        e_fexp = pend_exp;
                    end
                    e_fail++;
                end else begin
                    e_pass++;
                end
            end
            pend = xfer;
            if (xfer) begin
                pend_bad = model_bad(q_op[acc], q_a[acc], q_b[acc], q_r[acc]);
                pend_exp = model_exp(q_op[acc], q_a[acc], q_b[acc]);
                pend_r   = q_r[acc];
                pend_idx = acc;
                acc++;
            end
            check("pass_cnt", 64'(pass_cnt), 64'(e_pass));
            check("fail_cnt", 64'(fail_cnt), 64'(e_fail));
            if (abort_at >= 0 && acc == abort_at) break;
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (cycles >= 2000) check("timeout", 64'd1, 64'd0);
        if (abort_at >= 0) begin
            @(negedge clk);
            #2 reset = 1'b1;
            #1;
            check("rst_ready", 64'(in_ready), 64'd0);
            check("rst_mismatch", 64'(mismatch), 64'd0);
            check("rst_cnts", {32'(pass_cnt), 32'(fail_cnt)}, 64'd0);
            check("rst_first", {16'd0, 16'(first_idx), first_r}, 64'd0);
            check("rst_fexp", 64'(first_exp), 64'd0);
            check("rst_done", {62'd0, done, pass}, 64'd0);
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        #1;
        check("done_early", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        check("done", 64'(done), 64'd1);
        check("pass", 64'(pass), 64'(e_fail == 0));
        check("end_pass_cnt", 64'(pass_cnt), 64'(e_pass));
        check("end_fail_cnt", 64'(fail_cnt), 64'(e_fail));
        check("first_idx", 64'(first_idx), 64'(e_fidx));
        check("first_r", 64'(first_r), 64'(e_fr));
        check("first_exp", 64'(first_exp), 64'(e_fexp));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            check("done_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            check("done_hold", {31'd0, done, 16'(pass_cnt), 16'(fail_cnt)},
                  {31'd0, 1'b1, 16'(e_pass), 16'(e_fail)});
            check("done_mismatch", 64'(mismatch), 64'd0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num_vectors = '0;
        in_valid = 1'b0;
        in_op = '0;
        in_a = '0;
        in_b = '0;
        in_r = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {60'd0, in_ready, mismatch, done, pass}, 64'd0);
        check("reset_cnts", {32'(pass_cnt), 32'(fail_cnt)}, 64'd0);
        reset = 1'b0;

        clear_vecs();
        add_vec(3'b010, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF);
        run_session(0, -1, 0);

        clear_vecs();
        add_vec(3'b010, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
        add_vec(3'b010, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF);
        add_vec(3'b100, 32'h00000001, 32'hFFFFFFFF, 32'h00000000);
        run_session(0, -1, 0);

        clear_vecs();
        add_vec(3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
        add_vec(3'b111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000);
        run_session(0, -1, 0);

        clear_vecs();
        add_vec(3'b101, 32'h00000000, 32'h00000001, 32'h00000000);
        add_vec(3'b011, 32'h0F0F0F0F, 32'h00FF00FF, 32'h00000000);
        add_vec(3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        add_vec(3'b001, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF);
        run_session(0, -1, 0);

        clear_vecs();
        run_session(0, -1, 0);

        clear_vecs();
        add_random(4);
        run_session(0, 2, 0);
        clear_vecs();
        add_vec(3'b100, 32'h7FFFFFFF, 32'h00000001, 32'h80000000);
        run_session(0, -1, 0);

        for (int s = 0; s < 12; s++) begin
            clear_vecs();
            add_random($urandom_range(1, 24));
            run_session((s % 3) * 25, -1, (s % 2) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
